// File: rtl/csel_pkg.sv
// ---------------------------------------------------------------------------
// csel_pkg
// Shared constants for the pipelined carry-select adder.
//   CSEL_WIDTH   : default operand/result width
//   CSEL_BLOCK   : default carry-select segment width
//   csel_num_blk : number of segments, which is also the number of pipeline stages
// ---------------------------------------------------------------------------
package csel_pkg;

  localparam int CSEL_WIDTH = 32;
  localparam int CSEL_BLOCK = 8;

  // A non-positive block width is rejected at elaboration by the top.
  // Returning 1 here keeps the division well defined until that check fires.
  function automatic int csel_num_blk(input int width, input int block);
    if (block < 1) return 1;
    return width / block;
  endfunction

endpackage

// File: rtl/csel_segment.sv
// ---------------------------------------------------------------------------
// csel_segment
// Combinational BLOCK-bit carry-select slice. Both candidate sums (carry-in 0
// and carry-in 1) are formed in parallel, and the incoming carry only drives
// the final select.
// Ports:
//   i_a_seg   [BLOCK-1:0] operand A slice
//   i_b_seg   [BLOCK-1:0] effective operand B slice (already inverted for sub)
//   i_cin_sel             carry into this slice, used as the select
//   o_sum     [BLOCK-1:0] selected slice sum
//   o_cout                selected carry out of the slice
// ---------------------------------------------------------------------------
module csel_segment
  import csel_pkg::*;
#(
  parameter int BLOCK = CSEL_BLOCK
) (
  input  logic [BLOCK-1:0] i_a_seg,
  input  logic [BLOCK-1:0] i_b_seg,
  input  logic             i_cin_sel,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout
);

  logic [BLOCK:0] w_s0;
  logic [BLOCK:0] w_s1;

  assign w_s0 = {1'b0, i_a_seg} + {1'b0, i_b_seg};
  assign w_s1 = {1'b0, i_a_seg} + {1'b0, i_b_seg} + {{BLOCK{1'b0}}, 1'b1};

  assign {o_cout, o_sum} = i_cin_sel ? w_s1 : w_s0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// ---------------------------------------------------------------------------
// pipelined_csel_adder
// Pipelined carry-select add/subtract unit. The operand is split into
// NUM_BLK = WIDTH/BLOCK segments; stage k resolves segment k with the carry
// registered by stage k-1, so one result leaves per cycle after NUM_BLK cycles.
//   sub=0 : sum = a + b + cin,  cout = carry out
//   sub=1 : sum = a - b - cin,  cout = NOT borrow out
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   a, b [WIDTH-1:0]      operands
//   cin, sub              carry/borrow-in and operation select
//   out_valid / out_ready result handshake
//   sum [WIDTH-1:0], cout result and carry-out
//   ovf                   signed overflow, present only with CSEL_OVF_EN
// Build option: define CSEL_OVF_EN to add the ovf port and its logic.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The whole pipeline moves together (adv = !out_valid || out_ready);
// in_ready is exactly adv, so it depends combinationally on out_ready only.
// A held result (out_valid && !out_ready) freezes every stage, so sum/cout/ovf
// stay stable and nothing is dropped or duplicated. Empty slots travel as
// valid=0 bubbles.
// ---------------------------------------------------------------------------
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH,
  parameter int BLOCK = CSEL_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BLK_SAFE = (BLOCK < 1) ? 1 : BLOCK;
  localparam int NUM_BLK  = csel_num_blk(WIDTH, BLOCK);
  localparam int LAST     = NUM_BLK - 1;

  if ((BLOCK < 1) || ((WIDTH % BLK_SAFE) != 0)) begin : g_bad_cfg
    $fatal(1, "pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  // Values presented to stage k (stage 0 sees the ports, stage k the
  // registers of stage k-1).
  logic [WIDTH-1:0] w_src_a   [NUM_BLK];
  logic [WIDTH-1:0] w_src_b   [NUM_BLK];
  logic [WIDTH-1:0] w_src_sum [NUM_BLK];
  logic             w_src_c   [NUM_BLK];
  logic             w_src_vld [NUM_BLK];

  // Segment results and registered state of each stage.
  logic [BLOCK-1:0] w_seg_sum [NUM_BLK];
  logic             w_seg_c   [NUM_BLK];
  logic [WIDTH-1:0] w_stg_sum [NUM_BLK];
  logic             w_stg_c   [NUM_BLK];
  logic             w_stg_vld [NUM_BLK];

  assign w_adv    = !w_stg_vld[LAST] || out_ready;
  assign in_ready = w_adv;

  // Subtraction is a + ~b + ~cin; only stage 0 needs to know about sub.
  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub ? ~cin : cin;

  assign w_src_a[0]   = a;
  assign w_src_b[0]   = w_b_eff;
  assign w_src_sum[0] = '0;
  assign w_src_c[0]   = w_c0;
  assign w_src_vld[0] = in_valid;

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_stage
    logic [WIDTH-1:0] w_nxt_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_vld;

    csel_segment #(.BLOCK(BLOCK)) u_seg (
      .i_a_seg   (w_src_a[k][k*BLOCK +: BLOCK]),
      .i_b_seg   (w_src_b[k][k*BLOCK +: BLOCK]),
      .i_cin_sel (w_src_c[k]),
      .o_sum     (w_seg_sum[k]),
      .o_cout    (w_seg_c[k])
    );

    // Lower segments come through unchanged; segment k is filled in here.
    always_comb begin
      w_nxt_sum = w_src_sum[k];
      w_nxt_sum[k*BLOCK +: BLOCK] = w_seg_sum[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld   <= 1'b0;
        r_sum   <= '0;
        r_carry <= 1'b0;
      end else if (w_adv) begin
        r_vld   <= w_src_vld[k];
        r_sum   <= w_nxt_sum;
        r_carry <= w_seg_c[k];
      end
    end

    assign w_stg_sum[k] = r_sum;
    assign w_stg_c[k]   = r_carry;
    assign w_stg_vld[k] = r_vld;

    // Operands only need to travel on while a later stage still uses them.
    if (k < LAST) begin : g_fwd
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_src_a[k];
          r_b <= w_src_b[k];
        end
      end

      assign w_src_a[k+1]   = r_a;
      assign w_src_b[k+1]   = r_b;
      assign w_src_sum[k+1] = r_sum;
      assign w_src_c[k+1]   = r_carry;
      assign w_src_vld[k+1] = r_vld;
    end
  end

  assign out_valid = w_stg_vld[LAST];
  assign sum       = w_stg_sum[LAST];
  assign cout      = w_stg_c[LAST];

`ifdef CSEL_OVF_EN
  // Same-sign operands producing a result of the other sign. The MSB of the
  // result is produced by the last segment, so the flag is formed there.
  logic w_ovf_nxt;
  logic r_ovf;

  assign w_ovf_nxt = (w_src_a[LAST][WIDTH-1] == w_src_b[LAST][WIDTH-1]) &&
                     (w_seg_sum[LAST][BLOCK-1] != w_src_a[LAST][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_csel_adder
// Self-checking bench for pipelined_csel_adder (WIDTH=32, BLOCK=8).
// Directed vector table with hand-computed results and latency, back-to-back
// streaming, random backpressure with gapped input, and reset mid-stream.
// A scoreboard compares every delivered result with an arithmetic model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipelined_csel_adder;
  import csel_pkg::*;

  localparam int W  = 32;
  localparam int B  = 8;
  localparam int NB = csel_num_blk(W, B);

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CSEL_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(W), .BLOCK(B)) dut (
`ifdef CSEL_OVF_EN
    .ovf       (ovf),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on wider vectors.
  function automatic logic [W+1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                         input logic fc, input logic fs);
    logic [W:0]   wide;
    logic [W-1:0] s;
    logic         co;
    logic [W+1:0] sa;
    logic [W+1:0] sb;
    logic [W+1:0] sres;
    logic         ov;
    sa = {{2{fa[W-1]}}, fa};
    sb = {{2{fb[W-1]}}, fb};
    if (!fs) begin
      wide = {1'b0, fa} + {1'b0, fb} + {{W{1'b0}}, fc};
      s    = wide[W-1:0];
      co   = wide[W];
      sres = sa + sb + {{(W+1){1'b0}}, fc};
    end else begin
      s    = fa - fb - {{(W-1){1'b0}}, fc};
      co   = ({1'b0, fa} >= ({1'b0, fb} + {{W{1'b0}}, fc}));
      sres = sa - sb - {{(W+1){1'b0}}, fc};
    end
    // Signed result fits in W bits only if the top three bits agree.
    ov = !((sres[W+1] == sres[W]) && (sres[W] == sres[W-1]));
    return {ov, co, s};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0:       r = '0;
      1:       r = '1;
      2:       r = {1'b0, {(W-1){1'b1}}};
      3:       r = {1'b1, {(W-1){1'b0}}};
      default: r = W'($urandom());
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dc, input logic ds);
    in_valid = v;
    a        = da;
    b        = db;
    cin      = dc;
    sub      = ds;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum   = '0;
  logic         prev_cout  = 1'b0;

  initial begin : monitor
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready_eq_adv", 64'(in_ready), 64'(!out_valid || out_ready));
        if (prev_stall) begin
          check("stall_valid_held", 64'(out_valid), 64'(1));
          check("stall_sum_held", 64'(sum), 64'(prev_sum));
          check("stall_cout_held", 64'(cout), 64'(prev_cout));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got result 0x%0h required none at %0t", sum, $time);
          end else begin
            e = exp_q.pop_front();
            n_pop++;
            check("sb_sum", 64'(sum), 64'(e[W-1:0]));
            check("sb_cout", 64'(cout), 64'(e[W]));
`ifdef CSEL_OVF_EN
            check("sb_ovf", 64'(ovf), 64'(e[W+1]));
`endif
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, cin, sub));
          n_push++;
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
        prev_cout  = cout;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  initial begin : main
    int lat;
    int ones;
    int first;
    int stall_seen;
    int stale;
    int waited;
    logic last_acc;

    //            a             b             cin   sub   sum           cout  ovf
    vec[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vec[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vec[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vec[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vec[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vec[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    vec[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vec[7]  = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vec[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vec[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vec[10] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vec[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    // ---- reset ----
    #1 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
`ifdef CSEL_OVF_EN
    check("reset_ovf", 64'(ovf), 64'(0));
`endif
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("post_reset_in_ready", 64'(in_ready), 64'(1));
    check("post_reset_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;

    // ---- directed table: one transaction at a time, latency and value ----
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vec[i].a, vec[i].b, vec[i].cin, vec[i].sub);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      lat = 1;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NB));
      check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vec[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vec[i].cout));
`ifdef CSEL_OVF_EN
      check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vec[i].ovf));
`endif
    end
    repeat (3) step();

    // ---- streaming: 40 back-to-back random ops, out_ready held high ----
    ones       = 0;
    first      = -1;
    stall_seen = 0;
    for (int i = 0; i < 40 + NB + 2; i++) begin
      if (i < 40)
        drive(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        drive(1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      if (out_valid) begin
        ones++;
        if (first < 0) first = i;
      end
      if (i < 40 && !in_ready) stall_seen++;
      step();
    end
    check("stream_result_count", 64'(ones), 64'(40));
    check("stream_first_cycle", 64'(first), 64'(NB));
    check("stream_no_stall", 64'(stall_seen), 64'(0));

    // ---- backpressure: random out_ready, gapped input held until taken ----
    last_acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 99) < 50);
      if (!in_valid || last_acc) begin
        if ($urandom_range(0, 99) < 60)
          drive(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        else
          drive(1'b0, '0, '0, 1'b0, 1'b0);
      end
      @(negedge clk);
      last_acc = in_valid && in_ready;
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 50) begin
      step();
      waited++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    check("push_pop_balance", 64'(n_pop), 64'(n_push));

    // ---- reset with the pipeline full and stalled ----
    out_ready = 1'b0;
    for (int i = 0; i < NB + 1; i++) begin
      drive(1'b1, W'(32'h0000_1000 + i), 32'h0000_0022, 1'b0, 1'b0);
      step();
    end
    check("prefill_out_valid", 64'(out_valid), 64'(1));
    check("prefill_in_ready", 64'(in_ready), 64'(0));
    check("prefill_sum", 64'(sum), 64'(32'h0000_1022));
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_sum", 64'(sum), 64'(0));
    check("midreset_cout", 64'(cout), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
      step();
    end
    check("no_stale_after_reset", 64'(stale), 64'(0));

    // ---- one more transaction after reset to show the unit recovered ----
    drive(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("recover_latency", 64'(lat), 64'(NB));
    check("recover_sum", 64'(sum), 64'(32'h0000_0100));
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
- Parametrised, pipelined carry-select add/subtract unit. Successor to the fixed 32-bit combinational carry-select adder.
- Operand width is split into BLOCK-bit segments. Each segment precomputes sums for carry-in 0 and 1 and is registered in its own pipeline stage. Throughput is one operation per cycle.
- Sits between operand-producing datapath logic and result consumers. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, carry-select segment width; NUM_BLK = WIDTH/BLOCK pipeline stages.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  unit accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) / NOT borrow-out (sub).
- ovf  output  1  signed overflow (only when CSEL_OVF_EN defined).

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, all pipeline data registers 0. Outputs out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once reset is released.
- Effective operand: b_eff = sub ? ~b : b. Effective carry-in: c0 = sub ? ~cin : cin. Result = a + b_eff + c0 modulo 2^WIDTH; cout = carry out of the MSB.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational; it depends on out_ready, with no other path.
- Accept: the transaction is taken when in_valid && in_ready.
- Stage k (0..NUM_BLK-1) holds:
  - sum bits [(k+1)*BLOCK-1:0];
  - the carry out of segment k;
  - delayed, untouched a/b_eff upper segments;
  - a valid bit.
- On adv, stage k loads from stage k-1 (stage 0 loads from the inputs). It computes segment k as sel ? s1 : s0, where sel is the registered carry from stage k-1 (c0 for stage 0).
- Stage valid bits shift on adv. A bubble (in_valid=0) propagates as valid=0.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+NUM_BLK-1. Latency is NUM_BLK cycles, counting the accept edge as cycle 1.
- Stall: when out_valid && !out_ready, all stages hold and in_ready=0. No data loss or duplication.
- Output: sum/cout/ovf are driven from the last stage and stay stable while out_valid && !out_ready.
- Back-to-back operation: full throughput with out_ready held high. Mixed add/sub per transaction is allowed because sub is pipelined with its operands.
- Wrap-around: 0xFFFFFFFF + 1 gives sum 0, cout 1; no saturation.
- Reset mid-operation: all in-flight transactions are discarded with no output.
- Elaboration: fatal error if WIDTH % BLOCK != 0 or BLOCK < 1. NUM_BLK=1 degenerates to a single registered stage.

Optional Feature:
- Macro CSEL_OVF_EN.
- Defined: port ovf exists. ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), registered in the final stage alongside sum; reset 0.
- Not defined: no ovf port and no ovf logic.

Decomposition:
- Package csel_pkg: default WIDTH/BLOCK constants and the function computing NUM_BLK.
- Sub-module csel_segment: combinational BLOCK-bit unit. Inputs a_seg, b_seg, cin_sel; outputs the selected sum and carry, with both candidate sums computed internally. One instance per stage, via generate.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 in flight -> out_valid=0, sum=0 immediately. After release, no stale results.
- Add: a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 -> sum=0x0000_0100, cout=0, after 4 cycles (defaults).
- Wrap: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0, cout=1. Subtract: a=5, b=7, cin=0, sub=1 -> sum=0xFFFF_FFFE, cout=0.
- Streaming: 40 random pairs back-to-back with out_ready=1 -> results in order, one per cycle, each matching a reference model.
- Backpressure: out_ready toggled randomly, in_valid gapped -> in_ready==adv, no drops or duplicates, output stable during stall.
- CSEL_OVF_EN: a=0x7FFF_FFFF, b=1, add -> ovf=1. a=0x8000_0000, b=1, sub -> ovf=1. Also rerun with WIDTH=64, BLOCK=16.
